// File: rtl/Conv.sv
// Shared sizing and vector types for the convolution datapath.
package Conv;
  localparam int unsigned LEN   = 4;
  localparam int unsigned WIDTH = 64;
  typedef logic [LEN-1:0][WIDTH-1:0] data_vector;
endpackage

// File: rtl/conv_window_feeder_if.sv
// Sample, kernel-load and window handshakes between the feeder, its source and the operator.
interface conv_window_feeder_if #(
  parameter int unsigned LEN   = Conv::LEN,
  parameter int unsigned WIDTH = Conv::WIDTH
);
  logic [WIDTH-1:0]          sample;
  logic                      sample_valid;
  logic                      sample_last;
  logic                      sample_ready;
  logic [LEN-1:0][WIDTH-1:0] kernel_in;
  logic                      kernel_load;
  logic                      kernel_ready;
  logic [LEN-1:0][WIDTH-1:0] kernel;
  logic [LEN-1:0][WIDTH-1:0] window;
  logic                      win_valid;
  logic                      win_last;
  logic                      win_ready;
  logic                      short_frame;

  // Feeder side
  modport slave (
    input  sample, sample_valid, sample_last, kernel_in, kernel_load, win_ready,
    output sample_ready, kernel_ready, kernel, window, win_valid, win_last, short_frame
  );

  // Source / consumer side
  modport master (
    output sample, sample_valid, sample_last, kernel_in, kernel_load, win_ready,
    input  sample_ready, kernel_ready, kernel, window, win_valid, win_last, short_frame
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Builds sliding LEN-sample windows from a framed sample stream and holds a loadable kernel
// for the convolution operator, with a single registered output slot and full backpressure.
module conv_window_feeder #(
  parameter int unsigned LEN   = Conv::LEN,
  parameter int unsigned WIDTH = Conv::WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_feeder_if.slave bus
);
  localparam int unsigned FW = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t                    r_state;
  logic [FW-1:0]             r_fill;
  logic [LEN-1:0][WIDTH-1:0] r_sr;
  logic [LEN-1:0][WIDTH-1:0] r_window;
  logic [LEN-1:0][WIDTH-1:0] r_kernel;
  logic                      r_win_valid;
  logic                      r_win_last;
  logic                      r_short;

  logic                      w_sample_ready;
  logic                      w_kernel_ready;
  logic                      w_accept;
  logic [FW-1:0]             w_fill_n;
  logic                      w_full;
  logic [LEN-1:0][WIDTH-1:0] w_sr_n;

  // The slot frees up in the same cycle the consumer takes it.
  assign w_sample_ready = rst && (!r_win_valid || bus.win_ready);
  assign w_kernel_ready = rst && (r_state == IDLE) && !r_win_valid;
  assign w_accept       = bus.sample_valid && w_sample_ready;
  assign w_fill_n       = (r_fill == FW'(LEN)) ? r_fill : r_fill + FW'(1);
  assign w_full         = (w_fill_n == FW'(LEN));

  // Post-shift view: element 0 is the oldest sample.
  always_comb begin
    w_sr_n = r_sr;
    for (int i = 0; i < int'(LEN) - 1; i++) begin
      w_sr_n[i] = r_sr[i+1];
    end
    w_sr_n[LEN-1] = bus.sample;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_fill      <= '0;
      r_sr        <= '0;
      r_window    <= '0;
      r_kernel    <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_short <= 1'b0;

      if (w_accept) begin
        r_sr <= w_sr_n;
        if (bus.sample_last) begin
          r_fill  <= '0;
          r_state <= IDLE;
          r_short <= !w_full;
        end else begin
          r_fill  <= w_fill_n;
          r_state <= w_full ? STREAM : FILL;
        end
      end

      if (w_accept && w_full) begin
        r_window    <= w_sr_n;
        r_win_valid <= 1'b1;
        r_win_last  <= bus.sample_last;
      end else if (r_win_valid && bus.win_ready) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end

      if (bus.kernel_load && w_kernel_ready) begin
        r_kernel <= bus.kernel_in;
      end
    end
  end

  assign bus.sample_ready = w_sample_ready;
  assign bus.kernel_ready = w_kernel_ready;
  assign bus.kernel       = r_kernel;
  assign bus.window       = r_window;
  assign bus.win_valid    = r_win_valid;
  assign bus.win_last     = r_win_last;
  assign bus.short_frame  = r_short;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: expected windows are queued as frames are driven
// and checked in order whenever the consumer takes a window.
module tb_conv_window_feeder;
  typedef struct {
    Conv::data_vector w;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tb_win_ready = 1'b0;
  logic op_mode = 1'b0;
  logic op_ready = 1'b0;
  logic [3:0] op_cnt = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  conv_window_feeder_if bus ();

  conv_window_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the operator's registered in_ready: stalls one cycle in three.
  always @(posedge clk) begin
    op_cnt   <= op_cnt + 4'd1;
    op_ready <= (op_cnt % 4'd3) != 4'd0;
  end

  assign bus.win_ready = op_mode ? op_ready : tb_win_ready;

  function automatic Conv::data_vector mk(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
    Conv::data_vector v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input Conv::data_vector w, input logic last);
    exp_t e;
    e.w    = w;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every window handshake must match the oldest expected window.
  always @(negedge clk) begin
    if (rst && bus.win_valid && bus.win_ready) begin
      chk("window_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("window_data", bus.window, e.w);
        chk("window_last", 256'(bus.win_last), 256'(e.last));
      end
    end
  end

  // Present one sample and hold it until the feeder accepts it (bounded wait).
  task automatic send(input logic [63:0] v, input logic last);
    bit done;
    done = 1'b0;
    bus.sample       = v;
    bus.sample_last  = last;
    bus.sample_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.sample_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("sample_accept_timeout", 256'(0), 256'(1));
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    bus.sample_last  = 1'b0;
    bus.kernel_in    = '0;
    bus.kernel_load  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample_ready", 256'(bus.sample_ready), 256'(0));
    chk("rst_kernel_ready", 256'(bus.kernel_ready), 256'(0));
    chk("rst_win_valid", 256'(bus.win_valid), 256'(0));
    chk("rst_win_last", 256'(bus.win_last), 256'(0));
    chk("rst_short", 256'(bus.short_frame), 256'(0));
    chk("rst_window", bus.window, 256'(0));
    chk("rst_kernel", bus.kernel, 256'(0));
    rst = 1'b1;
    #1;
    chk("kernel_ready_idle", 256'(bus.kernel_ready), 256'(1));

    // Streaming frame
    bus.kernel_in   = mk(1, 2, 3, 4);
    bus.kernel_load = 1'b1;
    @(posedge clk);
    #1;
    bus.kernel_load = 1'b0;
    chk("kernel_loaded", bus.kernel, mk(1, 2, 3, 4));
    tb_win_ready = 1'b1;
    push(mk(1, 2, 3, 4), 1'b0);
    push(mk(2, 3, 4, 5), 1'b0);
    push(mk(3, 4, 5, 6), 1'b1);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    chk("no_window_before_full", 256'(bus.win_valid), 256'(0));
    send(4, 1'b0);
    chk("first_window_valid", 256'(bus.win_valid), 256'(1));
    chk("first_window_data", bus.window, mk(1, 2, 3, 4));
    send(5, 1'b0);
    chk("throughput_valid", 256'(bus.win_valid), 256'(1));
    send(6, 1'b1);
    chk("last_window_flag", 256'(bus.win_last), 256'(1));
    @(posedge clk);
    #1;
    chk("stream_drained", 256'(exp_q.size()), 256'(0));
    chk("valid_clears", 256'(bus.win_valid), 256'(0));

    // Backpressure
    tb_win_ready = 1'b0;
    push(mk(1, 2, 3, 4), 1'b0);
    push(mk(2, 3, 4, 5), 1'b0);
    push(mk(3, 4, 5, 6), 1'b1);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    bus.sample       = 5;
    bus.sample_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_sample_ready", 256'(bus.sample_ready), 256'(0));
      chk("bp_win_valid", 256'(bus.win_valid), 256'(1));
      chk("bp_window_stable", bus.window, mk(1, 2, 3, 4));
      chk("bp_kernel_ready", 256'(bus.kernel_ready), 256'(0));
    end
    @(posedge clk);
    #1;
    tb_win_ready = 1'b1;
    send(5, 1'b0);
    send(6, 1'b1);

    // Short frame, then a fresh frame must start from an empty window
    send(7, 1'b0);
    chk("short_not_yet", 256'(bus.short_frame), 256'(0));
    send(8, 1'b1);
    chk("short_pulse", 256'(bus.short_frame), 256'(1));
    chk("short_no_window", 256'(bus.win_valid), 256'(0));
    @(posedge clk);
    #1;
    chk("short_one_cycle", 256'(bus.short_frame), 256'(0));
    send(50, 1'b0);
    send(51, 1'b0);
    send(52, 1'b0);
    chk("refill_from_zero", 256'(bus.win_valid), 256'(0));
    push(mk(50, 51, 52, 53), 1'b1);
    send(53, 1'b1);
    chk("refill_window", bus.window, mk(50, 51, 52, 53));
    @(posedge clk);
    #1;

    // Blocked kernel load mid-frame, then accepted in IDLE
    send(20, 1'b0);
    bus.kernel_in   = mk(9, 9, 9, 9);
    bus.kernel_load = 1'b1;
    #1;
    chk("kload_blocked_ready", 256'(bus.kernel_ready), 256'(0));
    @(posedge clk);
    #1;
    bus.kernel_load = 1'b0;
    chk("kload_blocked_kernel", bus.kernel, mk(1, 2, 3, 4));
    send(21, 1'b1);
    bus.kernel_load = 1'b1;
    #1;
    chk("kload_idle_ready", 256'(bus.kernel_ready), 256'(1));
    @(posedge clk);
    #1;
    bus.kernel_load = 1'b0;
    chk("kload_idle_kernel", bus.kernel, mk(9, 9, 9, 9));

    // Reset mid-frame; kernel load and sample accept share the first IDLE cycle afterwards
    send(30, 1'b0);
    send(31, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_kernel", bus.kernel, 256'(0));
    chk("midrst_sample_ready", 256'(bus.sample_ready), 256'(0));
    chk("midrst_kernel_ready", 256'(bus.kernel_ready), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.kernel_in   = mk(5, 6, 7, 8);
    bus.kernel_load = 1'b1;
    push(mk(10, 11, 12, 13), 1'b1);
    send(10, 1'b0);
    bus.kernel_load = 1'b0;
    chk("kload_with_sample", bus.kernel, mk(5, 6, 7, 8));
    send(11, 1'b0);
    send(12, 1'b0);
    chk("midrst_no_stale_window", 256'(bus.win_valid), 256'(0));
    send(13, 1'b1);
    chk("midrst_first_window", bus.window, mk(10, 11, 12, 13));
    @(posedge clk);
    #1;

    // Operator-driven handshake
    op_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(mk(64'(40 + i), 64'(41 + i), 64'(42 + i), 64'(43 + i)), 1'(i == 4));
    end
    for (int i = 0; i < 8; i++) begin
      send(64'(40 + i), 1'(i == 7));
    end
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == 0 && !bus.win_valid) break;
      @(posedge clk);
      #1;
    end
    chk("op_all_consumed", 256'(exp_q.size()), 256'(0));
    chk("op_slot_empty", 256'(bus.win_valid), 256'(0));
    op_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of the convolution datapath. Accepts a framed stream of scalar samples over a valid/ready handshake and builds sliding windows of `LEN` consecutive samples. Each window is presented as a `Conv::data_vector` together with a stable, loadable kernel vector, and is handed to the convolution operator's `data`/`kernel`/`in_valid`/`in_ready` inputs. One window is produced per accepted sample once the window is full, with a registered output slot and full backpressure.

## Interface

Parameters:
- `LEN`, default `Conv::LEN` (4): samples per window; must be ≥2.
- `WIDTH`, default `Conv::WIDTH` (64): bits per sample and per kernel tap.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sample` input `WIDTH`: upstream sample.
- `sample_valid` input 1: `sample` and `sample_last` are valid.
- `sample_last` input 1: marks the final sample of a frame.
- `sample_ready` output 1: the feeder can accept a sample this cycle.
- `kernel_in` input `Conv::data_vector`: new kernel taps.
- `kernel_load` input 1: load request for `kernel_in`.
- `kernel_ready` output 1: a kernel load is accepted this cycle.
- `kernel` output `Conv::data_vector`: registered kernel; connects to the operator's `kernel`.
- `window` output `Conv::data_vector`: registered window; connects to the operator's `data`.
- `win_valid` output 1: `window` is valid; connects to the operator's `in_valid`.
- `win_last` output 1: this window ends a frame.
- `win_ready` input 1: the consumer takes the window; driven by the operator's `in_ready`.
- `short_frame` output 1: one-cycle pulse when a frame ended with fewer than `LEN` samples.

## Operation

**State.** The block keeps:
- a shift register `sr[0..LEN-1]`;
- a fill counter `fill` in the range 0..`LEN` (width `$clog2(LEN+1)`);
- an FSM with states:
  - IDLE: `fill`=0.
  - FILL: 0<`fill`<`LEN`.
  - STREAM: `fill`=`LEN`.

**Sample acceptance.** `accept = sample_valid && sample_ready`.
- `sample_ready = rst && (!win_valid || win_ready)`. This is combinational. It is forced to 0 while reset is asserted.
- On `accept`, the shift register updates as `sr[i] <= sr[i+1]` for i<`LEN-1`, and `sr[LEN-1] <= sample`. Element 0 is the oldest sample.
- The new fill value is `fill_n = min(fill+1, LEN)`.

**Window emission.**
- On `accept` with `fill_n == LEN`:
  - `window <= {sr[1..LEN-1], sample}`, i.e. the post-shift contents.
  - `win_valid <= 1`.
  - `win_last <= sample_last`.
- Otherwise, if `win_valid && win_ready`, then `win_valid <= 0` and `win_last <= 0`.
- `window` holds its value while `win_valid && !win_ready`.

**Frame end.** An `accept` with `sample_last=1` sets `fill <= 0` and moves the FSM to IDLE.
- If `fill_n < LEN` in that case, `short_frame` pulses high for exactly the next cycle, and no window is emitted.
- The contents of `sr` are not cleared; they are don't-care once `fill`=0.

**FSM transitions.**
- IDLE → FILL on `accept` without `sample_last`.
- FILL → STREAM when `fill_n == LEN`.
- STREAM stays in STREAM on each `accept`.
- Any state → IDLE on `accept` with `sample_last`.

**Kernel loading.**
- `kernel_ready = rst && (state == IDLE) && !win_valid`.
- On `kernel_load && kernel_ready`, `kernel <= kernel_in`.
- A load request while `kernel_ready`=0 is ignored; it is not queued.
- A kernel load and a sample accept in the same IDLE cycle are both performed.
- `kernel` never changes while a window is outstanding or mid-frame.

**Arithmetic.** No arithmetic is performed on the data; samples pass through bit-exact.

## Timing

- Reset values:
  - `window`, `kernel` = 0.
  - `win_valid`, `win_last`, `short_frame` = 0.
  - `fill` = 0; FSM in IDLE.
  - `sample_ready`, `kernel_ready` = 0 while `rst`=0.
- Latency: `win_valid` rises on the edge that accepts the `LEN`-th sample of a frame, and then on every subsequent accepted sample in that frame.
- Throughput: one window per cycle when `win_ready` is held at 1.
- Backpressure: while `win_valid && !win_ready`, `sample_ready`=0. A window is never overwritten or dropped.
- Simultaneous events: if the consumer takes a window and a new sample arrives in the same cycle, the new window is loaded and `win_valid` stays 1.
- Reset mid-frame: the reset takes effect immediately. Any pending window is discarded, and `kernel` returns to 0.

## Test plan

- **Streaming frame.** Load kernel {1,2,3,4} in IDLE, then send samples 1..6 with `sample_last` on 6 and `win_ready`=1. Required: exactly 3 windows, {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; `win_last` set only on the third; first `win_valid` on the cycle after sample 4 is accepted.
- **Backpressure.** Same frame as above, but `win_ready` is held at 0 for 5 cycles after the first window. Required: `window`={1,2,3,4} stays stable; `sample_ready`=0 throughout; no sample is lost; the window sequence is unchanged.
- **Short frame.** Send samples 7, 8 with `sample_last` on 8. Required: no `win_valid`; `short_frame` high for exactly 1 cycle; the next frame starts with `fill`=0.
- **Blocked kernel load.** Assert `kernel_load` with {9,9,9,9} mid-frame. Required: `kernel_ready`=0 and `kernel` unchanged. Then assert the same load in IDLE with no window outstanding. Required: `kernel`={9,9,9,9}.
- **Reset mid-frame.** Assert reset after 2 samples of a frame, then release it and send 4 fresh samples 10..13. Required: first window is {10,11,12,13}; `kernel`=0 after the reset.
- **Operator handshake.** Drive `win_ready` from the convolution operator's registered `in_ready`. Required: each window is consumed exactly once, in order.
